// File: rtl/funnel_gather.sv
// -----------------------------------------------------------------------------
// funnel_gather
// Reassembles a wide word of CHUNKS x CHUNK_W bits from narrow chunks that
// arrive on up to four lanes per beat. Each beat fills 1, 2 or 4 consecutive
// chunk slots; once all slots are filled the word is moved into a registered
// output slot, which is double-buffered against the accumulator so that
// back-to-back words flow without bubbles.
//
// Optional feature macro: FUNNEL_GATHER_FLUSH_EN
//   When defined, a t_flush input lets a partially filled word be emitted,
//   with its unfilled chunks zero.
//
// Ports
//   clk                  clock
//   reset_n              asynchronous, active-low reset
//   t_0..3_req           lane chunk valid
//   t_0..3_ack           lane chunk accepted (all-or-nothing per beat)
//   t_0..3_dat           lane chunk data, CHUNK_W bits
//   mode                 mode[STEPS-1:0] = one-hot lane count {4,2,1}
//   t_flush              flush partial word (FUNNEL_GATHER_FLUSH_EN only)
//   i_0_req              wide word valid
//   i_0_ack              wide word accepted
//   i_0_dat              wide word; chunk k at [k*CHUNK_W +: CHUNK_W]
// -----------------------------------------------------------------------------
module funnel_gather #(
    parameter int CHUNK_W = 128
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      t_0_req,
    output logic                      t_0_ack,
    input  logic [CHUNK_W-1:0]        t_0_dat,
    input  logic                      t_1_req,
    output logic                      t_1_ack,
    input  logic [CHUNK_W-1:0]        t_1_dat,
    input  logic                      t_2_req,
    output logic                      t_2_ack,
    input  logic [CHUNK_W-1:0]        t_2_dat,
    input  logic                      t_3_req,
    output logic                      t_3_ack,
    input  logic [CHUNK_W-1:0]        t_3_dat,
    input  logic [7:0]                mode,
`ifdef FUNNEL_GATHER_FLUSH_EN
    input  logic                      t_flush,
`endif
    output logic                      i_0_req,
    input  logic                      i_0_ack,
    output logic [8*CHUNK_W-1:0]      i_0_dat
);

    localparam int LANES  = 4;
    localparam int CHUNKS = 2 * LANES;
    localparam int STEPS  = $clog2(CHUNKS);
    localparam int SW     = STEPS + 1;

    logic [CHUNK_W-1:0]        lane_dat [LANES];
    logic [LANES-1:0]          lane_req;
    logic [LANES-1:0]          lane_ack;
    logic [LANES-1:0]          active;

    logic [STEPS-1:0]          state;
    logic [STEPS-1:0]          mode_q;
    logic [STEPS-1:0]          reduct_eff;
    logic [STEPS-1:0]          next_state;
    logic [CHUNKS*CHUNK_W-1:0] acc;
    logic [CHUNKS*CHUNK_W-1:0] merged;

    logic                      valid_mode;
    logic                      all_req;
    logic                      last_beat;
    logic                      slot_free;
    logic                      accept;
    logic                      flush_fire;
    logic                      unused_mode;

    assign lane_req    = {t_3_req, t_2_req, t_1_req, t_0_req};
    assign lane_dat[0] = t_0_dat;
    assign lane_dat[1] = t_1_dat;
    assign lane_dat[2] = t_2_dat;
    assign lane_dat[3] = t_3_dat;
    assign {t_3_ack, t_2_ack, t_1_ack, t_0_ack} = lane_ack;

    // Only the low STEPS bits of mode select the lane count.
    assign unused_mode = ^mode[7:STEPS];

    // A new word takes its lane count from the live mode input; once the
    // word has started, the captured value is held so mid-word mode changes
    // cannot misalign the chunk slots.
    assign reduct_eff = (state == '0) ? mode[STEPS-1:0] : mode_q;

    // Legal lane counts are single powers of two no larger than LANES.
    assign valid_mode = (reduct_eff != '0)
                     && ((reduct_eff & (reduct_eff - STEPS'(1))) == '0)
                     && ({1'b0, reduct_eff} <= SW'(LANES));

    for (genvar g = 0; g < LANES; g++) begin : g_active
        assign active[g] = valid_mode && (SW'(g) < {1'b0, reduct_eff});
    end

    assign all_req    = &(lane_req | ~active);
    assign next_state = state + reduct_eff;
    assign last_beat  = (next_state == '0);
    assign slot_free  = ~i_0_req | i_0_ack;

    // Only the word-completing beat needs the output slot to be free.
    assign accept     = valid_mode & all_req & (~last_beat | slot_free);
    assign lane_ack   = active & {LANES{accept}};

`ifdef FUNNEL_GATHER_FLUSH_EN
    assign flush_fire = t_flush && (state != '0) && !accept && slot_free;
`else
    assign flush_fire = 1'b0;
`endif

    // Accumulator with this beat's chunks overlaid at slots state+j.
    always_comb begin
        merged = acc;
        for (int k = 0; k < CHUNKS; k++) begin
            for (int j = 0; j < LANES; j++) begin
                if (active[j] && ((state + STEPS'(j)) == STEPS'(k))) begin
                    merged[k*CHUNK_W +: CHUNK_W] = lane_dat[j];
                end
            end
        end
    end

    // Fill pointer, accumulator and output slot. A completing beat (or a
    // flush) hands the word to the output register and restarts at slot 0;
    // the output valid drops on ack unless a new word lands the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= '0;
            mode_q  <= '0;
            acc     <= '0;
            i_0_req <= 1'b0;
            i_0_dat <= '0;
        end else begin
            if (accept) begin
                state <= next_state;
                if (state == '0) begin
                    mode_q <= reduct_eff;
                end
                if (last_beat) begin
                    i_0_dat <= merged;
                    acc     <= '0;
                end else begin
                    acc     <= merged;
                end
            end else if (flush_fire) begin
                i_0_dat <= acc;
                acc     <= '0;
                state   <= '0;
            end

            if ((accept && last_beat) || flush_fire) begin
                i_0_req <= 1'b1;
            end else if (i_0_ack) begin
                i_0_req <= 1'b0;
            end
        end
    end

endmodule
